// File: rtl/hq2x_seq_pkg.sv
// hq2x_seq_pkg: shared state encoding and timing constants for the Hq2x sequencer.
package hq2x_seq_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam int HQ_IN_PIXELS = 256;
  localparam int HQ_PIX_PHASE = 3;
  localparam int DEF_LINE_CLKS = 1364;
  localparam int DEF_FRAME_LINES = 262;
  localparam int DEF_ACTIVE_LINES = 240;
  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 64;
  localparam int DEF_VS_LINE = 245;
endpackage

// File: rtl/hq2x_line_timer.sv
// hq2x_line_timer: per-half-line output timing; read_x is combinational, de/hsync lag it by one clock.
module hq2x_line_timer
  import hq2x_seq_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcyc,
  input  logic        half,
  input  logic        de_en,
  output logic        vga_de,
  output logic        vga_hsync,
  output logic [9:0]  hq_read_x
);
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  logic act;
  assign act = hcyc < HA;
  assign hq_read_x = act ? {half, hcyc[8:0]} : 10'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_de    <= 1'b0;
      vga_hsync <= 1'b0;
    end else begin
      vga_de    <= de_en && act;
      vga_hsync <= hcyc >= HS0 && hcyc < HS1;
    end
  end
endmodule

// File: rtl/hq2x_sequencer.sv
// hq2x_sequencer: input pacing and 2x output timing around one Hq2x core.
// Define HQ2X_SEQ_UNDERFLOW_EN to enable FIFO underflow detection and black substitution.
module hq2x_sequencer
  import hq2x_seq_pkg::*;
#(
  parameter int LINE_CLKS    = DEF_LINE_CLKS,
  parameter int FRAME_LINES  = DEF_FRAME_LINES,
  parameter int ACTIVE_LINES = DEF_ACTIVE_LINES,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int VS_LINE      = DEF_VS_LINE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_avail,
  output logic       pix_req,
  output logic       pix_black,
  output logic       hq_reset_line,
  output logic       hq_reset_frame,
  output logic [9:0] hq_read_x,
  input  logic       hq_frame_available,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_de,
  output logic       underflow
);
  localparam logic [10:0] LC_LAST = 11'(LINE_CLKS - 1);
  localparam logic [10:0] LC_HALF = 11'(LINE_CLKS / 2);
  localparam logic [10:0] PIX_END = 11'(4 * HQ_IN_PIXELS);
  localparam logic [8:0]  LN_LAST = 9'(FRAME_LINES - 1);
  localparam logic [8:0]  LN_ACT  = 9'(ACTIVE_LINES);
  localparam logic [8:0]  LN_VS   = 9'(VS_LINE);
  state_t state, state_n;
  logic [10:0] lcyc, hcyc;
  logic [8:0] lnum;
  logic fa_seen, half, line_end, active, de_en;
  assign line_end = lcyc == LC_LAST;
  assign half     = lcyc >= LC_HALF;
  assign hcyc     = half ? lcyc - LC_HALF : lcyc;
  assign active   = state != IDLE;
  assign de_en    = state == RUN && lnum >= 9'd1 && lnum <= LN_ACT;
  assign hq_reset_line  = active && lcyc == 11'd0;
  assign hq_reset_frame = hq_reset_line && lnum == 9'd0;
  assign pix_req = active && lnum < LN_ACT && lcyc < PIX_END && lcyc[1:0] == 2'(HQ_PIX_PHASE);
  // RUN begins on the line boundary after Hq2x first reports a complete frame
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? PRIME :
              (state == PRIME && line_end && (fa_seen || hq_frame_available)) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lcyc      <= 11'd0;
      lnum      <= 9'd0;
      fa_seen   <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      state     <= state_n;
      lcyc      <= (!active || line_end) ? 11'd0 : lcyc + 11'd1;
      lnum      <= !active ? 9'd0 : line_end ? (lnum == LN_LAST ? 9'd0 : lnum + 9'd1) : lnum;
      fa_seen   <= state == PRIME && (fa_seen || hq_frame_available);
      vga_vsync <= lnum == LN_VS;
    end
  end
`ifdef HQ2X_SEQ_UNDERFLOW_EN
  assign pix_black = pix_req && !pix_avail;
  always_ff @(posedge clk) begin
    if (reset) underflow <= 1'b0;
    else if (pix_black) underflow <= 1'b1;
  end
`else
  logic unused_pix_avail;
  assign unused_pix_avail = pix_avail;
  assign pix_black = 1'b0;
  assign underflow = 1'b0;
`endif
  hq2x_line_timer #(.H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .hcyc     (hcyc),
    .half     (half),
    .de_en    (de_en),
    .vga_de   (vga_de),
    .vga_hsync(vga_hsync),
    .hq_read_x(hq_read_x)
  );
endmodule

// File: tb/tb_hq2x_sequencer.sv
// tb_hq2x_sequencer: directed line-by-line scans with hand-computed per-line and per-frame totals.
module tb_hq2x_sequencer;
  localparam int LC = 1364, FL = 12, AL = 8, VS = 10;
`ifdef HQ2X_SEQ_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, pix_avail = 1'b1, hq_frame_available = 1'b0;
  logic pix_req, pix_black, hq_reset_line, hq_reset_frame, vga_hsync, vga_vsync, vga_de, underflow;
  logic [9:0] hq_read_x;
  hq2x_sequencer #(.LINE_CLKS(LC), .FRAME_LINES(FL), .ACTIVE_LINES(AL), .VS_LINE(VS)) dut (
    .clk(clk), .reset(reset), .pix_avail(pix_avail), .pix_req(pix_req), .pix_black(pix_black),
    .hq_reset_line(hq_reset_line), .hq_reset_frame(hq_reset_frame), .hq_read_x(hq_read_x),
    .hq_frame_available(hq_frame_available), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .underflow(underflow)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  int n_req, first_req, last_req, bad_req, n_de, first_de, n_hs, first_hs, n_rl, rl_at, n_rf;
  int n_black, black_at, uf_at, fa_cyc = -1, uf_cyc = -1;
  int f_req, f_de, f_rise, f_vs, f_rf, blank_req;
  logic prev_de = 1'b0;
  logic [9:0] rx [LC];
  logic hs [LC];
  logic de [LC];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] all_outs();
    return {14'd0, pix_req, pix_black, hq_reset_line, hq_reset_frame, vga_hsync, vga_vsync,
            vga_de, underflow, hq_read_x};
  endfunction
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_line();
    n_req = 0; first_req = -1; last_req = -1; bad_req = 0; n_de = 0; first_de = -1;
    n_hs = 0; first_hs = -1; n_rl = 0; rl_at = -1; n_rf = 0; n_black = 0; black_at = -1; uf_at = -1;
    for (int c = 0; c < LC; c++) begin
      pix_avail = (c != uf_cyc);
      hq_frame_available = (c == fa_cyc);
      #1;
      if (pix_req) begin
        n_req++;
        if (first_req < 0) first_req = c;
        last_req = c;
        if (c % 4 != 3) bad_req++;
      end
      if (vga_de) begin
        n_de++;
        if (first_de < 0) first_de = c;
        if (!prev_de) f_rise++;
      end
      prev_de = vga_de;
      if (vga_hsync) begin
        n_hs++;
        if (first_hs < 0) first_hs = c;
      end
      if (hq_reset_line) begin
        n_rl++;
        if (rl_at < 0) rl_at = c;
      end
      if (hq_reset_frame) n_rf++;
      if (pix_black) begin
        n_black++;
        if (black_at < 0) black_at = c;
      end
      if (underflow && uf_at < 0) uf_at = c;
      rx[c] = hq_read_x;
      hs[c] = vga_hsync;
      de[c] = vga_de;
      f_req += n_req == 0 ? 0 : (pix_req ? 1 : 0);
      f_de += vga_de ? 1 : 0;
      f_vs += vga_vsync ? 1 : 0;
      f_rf += hq_reset_frame ? 1 : 0;
      step();
    end
    pix_avail = 1'b1;
    hq_frame_available = 1'b0;
  endtask
  task automatic clear_frame();
    f_req = 0; f_de = 0; f_rise = 0; f_vs = 0; f_rf = 0; blank_req = 0;
  endtask
  initial begin
    clear_frame();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("reset_outputs", all_outs(), 0);
    reset = 1'b0;
    #1 check("idle_no_reset_line", {31'd0, hq_reset_line}, 0);
    step();
    check("first_reset_line", {31'd0, hq_reset_line}, 1);
    check("first_reset_frame", {31'd0, hq_reset_frame}, 1);
    // frame 0: line 0 in PRIME
    run_line();
    check("l0_rl_at", rl_at, 0);
    check("l0_n_rl", n_rl, 1);
    check("l0_n_rf", n_rf, 1);
    check("l0_n_req", n_req, 256);
    check("l0_first_req", first_req, 3);
    check("l0_last_req", last_req, 1023);
    check("l0_bad_req", bad_req, 0);
    check("rx_0", rx[0], 0);
    check("rx_511", rx[511], 511);
    check("rx_512", rx[512], 0);
    check("rx_682", rx[682], 512);
    check("rx_1193", rx[1193], 1023);
    check("rx_1194", rx[1194], 0);
    check("hs_count", n_hs, 128);
    check("hs_first", first_hs, 529);
    check("hs_last_hi", {31'd0, hs[592]}, 1);
    check("hs_after_lo", {31'd0, hs[593]}, 0);
    check("prime_no_de", n_de, 0);
    uf_cyc = 43;
    run_line();
    uf_cyc = -1;
    check("uf_black_at", black_at, UF_EN ? 43 : -1);
    check("uf_black_cnt", n_black, UF_EN ? 1 : 0);
    check("uf_sticky_at", uf_at, UF_EN ? 44 : -1);
    check("uf_req_kept", n_req, 256);
    fa_cyc = 100;
    run_line();
    fa_cyc = -1;
    check("l2_no_de", n_de, 0);
    check("l2_no_rf", n_rf, 0);
    run_line();
    check("l3_first_de", first_de, 1);
    check("l3_de0_lo", {31'd0, de[0]}, 0);
    check("l3_n_de", n_de, 1024);
    for (int l = 4; l < FL; l++) begin
      run_line();
      if (l >= AL) blank_req += n_req;
    end
    check("f0_blank_req", blank_req, 0);
    check("f0_n_de", f_de, 6 * 1024);
    check("f0_vs", f_vs, LC);
    check("f0_rf", f_rf, 1);
    // frame 1: full RUN frame, wrap coincidence at line 0
    clear_frame();
    run_line();
    check("wrap_rl_at", rl_at, 0);
    check("wrap_rf", n_rf, 1);
    check("f1_l0_de", n_de, 0);
    for (int l = 1; l < FL; l++) begin
      run_line();
      if (l >= AL) blank_req += n_req;
    end
    check("f1_n_de", f_de, 8192);
    check("f1_de_lines", f_rise, 16);
    check("f1_blank_req", blank_req, 0);
    check("f1_rf", f_rf, 1);
    check("uf_still_sticky", {31'd0, underflow}, UF_EN ? 1 : 0);
    // frame 2: reset at lcyc=500 of line 5
    clear_frame();
    for (int l = 0; l < 5; l++) run_line();
    repeat (500) step();
    reset = 1'b1;
    step();
    #1 check("midline_reset_outs", all_outs(), 0);
    reset = 1'b0;
    step();
    check("rst_reframe", {31'd0, hq_reset_frame}, 1);
    clear_frame();
    run_line();
    run_line();
    fa_cyc = 5;
    run_line();
    fa_cyc = -1;
    check("post_rst_no_de", f_de, 0);
    check("post_rst_req", n_req, 256);
    run_line();
    check("post_rst_rerun_de", n_de, 1024);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
